// File: rtl/alien_formation_scheduler.sv
// alien_formation_scheduler
// Frame-level sequencer for the alien sprite drawer. On frame_start it walks
// the ROWS x COLS formation in row-major order, skips dead slots, and for each
// live slot presents the sprite base pixel, pulses draw_enable and waits for
// sprite_done before moving to the next slot.
//
// Optional feature: define ALIEN_FORMATION_ERASE_EN to paint the previous
// frame's formation in background colour (erase=1) before each draw pass.
//
// Ports:
//   clk          system clock
//   reset_n      synchronous active-low reset
//   frame_start  one-cycle request to draw the formation (ignored while busy)
//   origin_x/y   formation top-left pixel, latched on frame_start
//   alive        alive mask, bit index = row*COLS+col, latched on frame_start
//   draw_enable  one-cycle start pulse to the sprite drawer
//   sprite_done  drawer completion pulse (only honoured while waiting)
//   base_x/y     sprite base pixel for the slot being drawn
//   erase        1 = drawer paints background colour
//   busy         high whenever the sequencer is not idle
//   frame_done   one-cycle pulse when the formation pass completes
module alien_formation_scheduler #(
    parameter int unsigned COLS   = 8,
    parameter int unsigned ROWS   = 4,
    parameter int unsigned X_STEP = 8,
    parameter int unsigned Y_STEP = 6,
    parameter int unsigned XW     = 8,
    parameter int unsigned YW     = 7
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 frame_start,
    input  logic [XW-1:0]        origin_x,
    input  logic [YW-1:0]        origin_y,
    input  logic [ROWS*COLS-1:0] alive,
    output logic                 draw_enable,
    input  logic                 sprite_done,
    output logic [XW-1:0]        base_x,
    output logic [YW-1:0]        base_y,
    output logic                 erase,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int unsigned N  = ROWS * COLS;
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] CHECK     = 3'd1;
    localparam logic [2:0] ISSUE     = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] ADVANCE   = 3'd4;
    localparam logic [2:0] DONE      = 3'd5;

    logic [2:0]    state, state_n;
    logic [RW-1:0] row, row_n;
    logic [CW-1:0] col, col_n;
    logic [XW-1:0] org_x;
    logic [YW-1:0] org_y;
    logic [N-1:0]  org_alive;

    // Origin/mask of the pass currently being walked
    logic [XW-1:0] sel_x;
    logic [YW-1:0] sel_y;
    logic [N-1:0]  sel_alive;
    logic          slot_live;
    logic          last_col;
    logic          last_slot;

`ifdef ALIEN_FORMATION_ERASE_EN
    logic [XW-1:0] prev_origin_x;
    logic [YW-1:0] prev_origin_y;
    logic [N-1:0]  prev_alive;
    logic          prev_valid;
    logic          erase_n;

    // During the erase pass the previous frame's formation is walked
    always_comb begin
        sel_x     = erase ? prev_origin_x : org_x;
        sel_y     = erase ? prev_origin_y : org_y;
        sel_alive = erase ? prev_alive    : org_alive;
    end
`else
    always_comb begin
        sel_x     = org_x;
        sel_y     = org_y;
        sel_alive = org_alive;
    end

    assign erase = 1'b0;
`endif

    assign slot_live = sel_alive[IW'(32'(row) * COLS + 32'(col))];
    assign last_col  = (col == CW'(COLS - 1));
    assign last_slot = last_col && (row == RW'(ROWS - 1));

    // Next-state logic
    always_comb begin
        state_n = state;
        row_n   = row;
        col_n   = col;
`ifdef ALIEN_FORMATION_ERASE_EN
        erase_n = erase;
`endif
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_n = CHECK;
                    row_n   = '0;
                    col_n   = '0;
`ifdef ALIEN_FORMATION_ERASE_EN
                    erase_n = prev_valid;
`endif
                end
            end
            CHECK:     state_n = slot_live ? ISSUE : ADVANCE;
            ISSUE:     state_n = WAIT_DONE;
            WAIT_DONE: if (sprite_done) state_n = ADVANCE;
            ADVANCE: begin
                if (last_slot) begin
`ifdef ALIEN_FORMATION_ERASE_EN
                    // Erase pass rolls straight into the draw pass
                    if (erase) begin
                        erase_n = 1'b0;
                        row_n   = '0;
                        col_n   = '0;
                        state_n = CHECK;
                    end else begin
                        state_n = DONE;
                    end
`else
                    state_n = DONE;
`endif
                end else begin
                    if (last_col) begin
                        col_n = '0;
                        row_n = row + RW'(1);
                    end else begin
                        col_n = col + CW'(1);
                    end
                    state_n = CHECK;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State, latched inputs and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            row         <= '0;
            col         <= '0;
            org_x       <= '0;
            org_y       <= '0;
            org_alive   <= '0;
            draw_enable <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            base_x      <= '0;
            base_y      <= '0;
        end else begin
            state       <= state_n;
            row         <= row_n;
            col         <= col_n;
            draw_enable <= (state_n == ISSUE);
            busy        <= (state_n != IDLE);
            frame_done  <= (state_n == DONE);
            if (state == IDLE && frame_start) begin
                org_x     <= origin_x;
                org_y     <= origin_y;
                org_alive <= alive;
            end
            // row/col are stable from CHECK into ISSUE, so load on entry
            if (state_n == ISSUE) begin
                base_x <= XW'(32'(sel_x) + 32'(col) * X_STEP);
                base_y <= YW'(32'(sel_y) + 32'(row) * Y_STEP);
            end
        end
    end

`ifdef ALIEN_FORMATION_ERASE_EN
    // Previous-frame storage for the erase pass
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            erase         <= 1'b0;
            prev_valid    <= 1'b0;
            prev_origin_x <= '0;
            prev_origin_y <= '0;
            prev_alive    <= '0;
        end else begin
            erase <= erase_n;
            if (state == DONE) begin
                prev_origin_x <= org_x;
                prev_origin_y <= org_y;
                prev_alive    <= org_alive;
                prev_valid    <= 1'b1;
            end
        end
    end
`endif

endmodule
